// File: rtl/mem_stage_pkg.sv
// Shared LC-3b types for the memory stage: data word, memory-op encoding
// and small op-classification helpers.
package mem_stage_pkg;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [2:0] {
        MEM_NONE = 3'd0,
        MEM_LDR  = 3'd1,
        MEM_LDB  = 3'd2,
        MEM_STR  = 3'd3,
        MEM_STB  = 3'd4,
        MEM_LDI  = 3'd5,
        MEM_STI  = 3'd6
    } lc3b_mem_op;

    function automatic logic is_store(input lc3b_mem_op op);
        return (op == MEM_STR) || (op == MEM_STB) || (op == MEM_STI);
    endfunction

    function automatic logic is_byte(input lc3b_mem_op op);
        return (op == MEM_LDB) || (op == MEM_STB);
    endfunction

    function automatic logic is_indirect(input lc3b_mem_op op);
        return (op == MEM_LDI) || (op == MEM_STI);
    endfunction

    function automatic logic is_direct(input lc3b_mem_op op);
        return (op == MEM_LDR) || (op == MEM_LDB) || (op == MEM_STR) || (op == MEM_STB);
    endfunction

endpackage

// File: rtl/mem_byte_align.sv
// Byte-lane steering for dcache accesses: lane enables and replicated write
// data for stores, selected and sign-extended byte for LDB.
module mem_byte_align
    import mem_stage_pkg::*;
(
    input  logic        byte_sel,
    input  lc3b_mem_op  op,
    input  logic [15:0] store_data,
    input  logic [15:0] rdata,
    output logic [1:0]  be,
    output logic [15:0] wdata,
    output logic [15:0] load_value
);

    logic [7:0] sel_byte;

    always_comb begin
        be         = 2'b11;
        wdata      = store_data;
        load_value = rdata;
        sel_byte   = byte_sel ? rdata[15:8] : rdata[7:0];
        if (op == MEM_STB) begin
            be    = byte_sel ? 2'b10 : 2'b01;
            wdata = {2{store_data[7:0]}};
        end
        if (op == MEM_LDB) begin
            load_value = {{8{sel_byte[7]}}, sel_byte};
        end
    end

endmodule

// File: rtl/mem_stage.sv
// LC-3b memory-access stage: sequences dcache requests for direct and
// indirect loads/stores, stalls the pipeline until done, registers load data.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic [2:0]  mem_op,
    input  logic [15:0] addr,
    input  logic [15:0] store_data,
    output logic [15:0] dmem_address,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [1:0]  dmem_byte_enable,
    output logic [15:0] dmem_wdata,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        mem_stall,
    output logic [15:0] load_data,
    output logic        mem_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_IND  = 2'd1;
    localparam logic [1:0] S_ACC  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    logic [1:0]    state;
    lc3b_mem_op    op_in;
    lc3b_mem_op    cur_op;
    lc3b_mem_op    align_op;
    logic          align_bit;
    logic [1:0]    align_be;
    lc3b_word      align_wdata;
    lc3b_word      align_load;
    logic [CW-1:0] wait_cnt;
    logic          waiting;

    assign op_in = lc3b_mem_op'(mem_op);

    // Live inputs steer the first request; afterwards the latched op and the
    // registered address bit keep the lane logic stable for the whole access.
    assign align_op  = (state == S_IDLE) ? op_in : cur_op;
    assign align_bit = (state == S_IDLE) ? addr[0] : dmem_address[0];

    assign mem_stall = valid && (mem_op != 3'd0) && (state != S_DONE);
    assign waiting   = ((state == S_IND) || (state == S_ACC)) && !dmem_resp;

    mem_byte_align u_align (
        .byte_sel   (align_bit),
        .op         (align_op),
        .store_data (store_data),
        .rdata      (dmem_rdata),
        .be         (align_be),
        .wdata      (align_wdata),
        .load_value (align_load)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            cur_op           <= MEM_NONE;
            dmem_read        <= 1'b0;
            dmem_write       <= 1'b0;
            dmem_address     <= '0;
            dmem_wdata       <= '0;
            dmem_byte_enable <= '0;
            load_data        <= '0;
            mem_err          <= 1'b0;
            wait_cnt         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (valid && is_indirect(op_in)) begin
                        state            <= S_IND;
                        cur_op           <= op_in;
                        dmem_read        <= 1'b1;
                        dmem_write       <= 1'b0;
                        dmem_address     <= {addr[15:1], 1'b0};
                        dmem_byte_enable <= 2'b11;
                    end else if (valid && is_direct(op_in)) begin
                        state            <= S_ACC;
                        cur_op           <= op_in;
                        dmem_read        <= !is_store(op_in);
                        dmem_write       <= is_store(op_in);
                        dmem_address     <= is_byte(op_in) ? addr : {addr[15:1], 1'b0};
                        dmem_byte_enable <= align_be;
                        dmem_wdata       <= align_wdata;
                    end
                end
                S_IND: begin
                    if (dmem_resp) begin
                        state        <= S_ACC;
                        dmem_read    <= !is_store(cur_op);
                        dmem_write   <= is_store(cur_op);
                        dmem_address <= {dmem_rdata[15:1], 1'b0};
                        dmem_wdata   <= align_wdata;
                    end
                end
                S_ACC: begin
                    if (dmem_resp) begin
                        state      <= S_DONE;
                        dmem_read  <= 1'b0;
                        dmem_write <= 1'b0;
                        if (!is_store(cur_op)) begin
                            load_data <= align_load;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Counter saturates at MAX_WAIT; the access keeps waiting after the error flags.
            if (waiting) begin
                if (wait_cnt != CW'(MAX_WAIT)) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                if (wait_cnt == CW'(MAX_WAIT - 1)) begin
                    mem_err <= 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed LC-3b memory scenarios plus
// randomized direct/indirect traffic against a behavioural reference model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int MW = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [2:0]  mem_op = 3'd0;
    logic [15:0] addr = '0;
    logic [15:0] store_data = '0;
    logic [15:0] dmem_address;
    logic        dmem_read;
    logic        dmem_write;
    logic [1:0]  dmem_byte_enable;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata = '0;
    logic        dmem_resp = 1'b0;
    logic        mem_stall;
    logic [15:0] load_data;
    logic        mem_err;

    int passed = 0;
    int total = 0;
    int stall_cnt = 0;
    int unstable = 0;
    logic [15:0] model_load = '0;

    mem_stage #(.MAX_WAIT(MW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .valid            (valid),
        .mem_op           (mem_op),
        .addr             (addr),
        .store_data       (store_data),
        .dmem_address     (dmem_address),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_wdata       (dmem_wdata),
        .dmem_rdata       (dmem_rdata),
        .dmem_resp        (dmem_resp),
        .mem_stall        (mem_stall),
        .load_data        (load_data),
        .mem_err          (mem_err)
    );

    always #5 clk = ~clk;

    // Stall-cycle counter and request-stability monitor, sampled at the active edge.
    logic        prev_wait = 1'b0;
    logic [37:0] prev_req = '0;
    always @(posedge clk) begin
        if (mem_stall) stall_cnt++;
        if (!rst_n) begin
            prev_wait = 1'b0;
        end else begin
            if (prev_wait && ({dmem_address, dmem_wdata, dmem_byte_enable, dmem_read, dmem_write,
                               2'b00} !== prev_req)) unstable++;
            prev_wait = (dmem_read || dmem_write) && !dmem_resp;
            prev_req  = {dmem_address, dmem_wdata, dmem_byte_enable, dmem_read, dmem_write, 2'b00};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (passed=%0d total=%0d)", passed, total);
        $fatal(1);
    end

    function automatic logic is_st(input logic [2:0] op);
        return op == MEM_STR || op == MEM_STB || op == MEM_STI;
    endfunction

    function automatic logic [15:0] exp_addr(input logic [2:0] op, input logic [15:0] a);
        return (op == MEM_LDB || op == MEM_STB) ? a : 16'(a - (a % 2));
    endfunction

    function automatic logic [1:0] exp_be(input logic [2:0] op, input logic [15:0] a);
        return (op == MEM_STB) ? 2'(1 << (a % 2)) : 2'd3;
    endfunction

    function automatic logic [15:0] exp_wdata(input logic [2:0] op, input logic [15:0] sd);
        return (op == MEM_STB) ? 16'((sd % 256) * 257) : sd;
    endfunction

    function automatic logic [15:0] exp_load(input logic [2:0] op, input logic [15:0] a,
                                             input logic [15:0] rd);
        int b;
        if (op != MEM_LDB) return rd;
        b = (int'(rd) >> (8 * (a % 2))) % 256;
        return (b >= 128) ? 16'(b + 65280) : 16'(b);
    endfunction

    // Drives one instruction at the current negedge and plays the dcache; returns at the DONE negedge.
    task automatic run_op(input logic [2:0] op, input logic [15:0] a, sd, ptr, rd, input int lat,
                          output logic [15:0] a1, a2, wd, output logic [1:0] be,
                          output logic rq, wq, output int first_wait, stalls, output logic done_stall);
        int s0, n, phases;
        a1 = '0; a2 = '0; wd = '0; be = '0; rq = 1'b0; wq = 1'b0;
        first_wait = -1; stalls = -1; done_stall = 1'b1;
        s0 = stall_cnt;
        valid = 1'b1; mem_op = op; addr = a; store_data = sd;
        phases = (op == MEM_LDI || op == MEM_STI) ? 2 : 1;
        for (int ph = 0; ph < phases; ph++) begin
            n = 0;
            while (!(dmem_read || dmem_write) && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (ph == 0) first_wait = n;
            if (!(dmem_read || dmem_write)) begin
                total++;
                $display("FAIL request_timeout: no dcache request after %0d cycles, required one", n);
                valid = 1'b0;
                return;
            end
            if (ph == 0) a1 = dmem_address;
            a2 = dmem_address; wd = dmem_wdata; be = dmem_byte_enable;
            rq = dmem_read; wq = dmem_write;
            repeat (lat - 1) @(negedge clk);
            dmem_rdata = (ph == 0 && phases == 2) ? ptr : rd;
            dmem_resp = 1'b1;
            @(negedge clk);
            dmem_resp = 1'b0;
            dmem_rdata = 16'($urandom);
        end
        stalls = stall_cnt - s0;
        done_stall = mem_stall;
    endtask

    task automatic idle_cycle();
        valid = 1'b0; mem_op = MEM_NONE;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if ({dmem_read, dmem_write} !== 2'b00) $display("FAIL reset_req: got %b required 00", {dmem_read, dmem_write}); else passed++;
        total++; if (dmem_address !== 16'h0) $display("FAIL reset_addr: got %h required 0000", dmem_address); else passed++;
        total++; if ({dmem_wdata, dmem_byte_enable} !== 18'h0) $display("FAIL reset_wdata_be: got %h/%b required 0", dmem_wdata, dmem_byte_enable); else passed++;
        total++; if (load_data !== 16'h0) $display("FAIL reset_load: got %h required 0000", load_data); else passed++;
        total++; if ({mem_err, mem_stall} !== 2'b00) $display("FAIL reset_err_stall: got %b required 00", {mem_err, mem_stall}); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ldr();
        logic [15:0] a1, a2, wd; logic [1:0] be; logic rq, wq, ds; int fw, st;
        run_op(MEM_LDR, 16'h3001, 16'h0, 16'h0, 16'hBEEF, 3, a1, a2, wd, be, rq, wq, fw, st, ds);
        total++; if ({a1, be, rq, wq} !== {16'h3000, 2'b11, 1'b1, 1'b0}) $display("FAIL ldr_req: got addr=%h be=%b r=%b w=%b required 3000/11/1/0", a1, be, rq, wq); else passed++;
        total++; if (st !== 4) $display("FAIL ldr_stall_cycles: got %0d required 4", st); else passed++;
        total++; if (ds !== 1'b0) $display("FAIL ldr_done_stall: got %b required 0", ds); else passed++;
        total++; if (load_data !== 16'hBEEF) $display("FAIL ldr_load: got %h required beef", load_data); else passed++;
        model_load = 16'hBEEF;
        idle_cycle();
    endtask

    task automatic test_ldb();
        logic [15:0] a1, a2, wd; logic [1:0] be; logic rq, wq, ds; int fw, st;
        run_op(MEM_LDB, 16'h3001, 16'h0, 16'h0, 16'h80FF, 2, a1, a2, wd, be, rq, wq, fw, st, ds);
        total++; if (a1 !== 16'h3001) $display("FAIL ldb_addr: got %h required 3001", a1); else passed++;
        total++; if (load_data !== 16'hFF80) $display("FAIL ldb_hi_load: got %h required ff80", load_data); else passed++;
        run_op(MEM_LDB, 16'h3000, 16'h0, 16'h0, 16'h80FF, 1, a1, a2, wd, be, rq, wq, fw, st, ds);
        total++; if (load_data !== 16'hFFFF) $display("FAIL ldb_lo_load: got %h required ffff", load_data); else passed++;
        model_load = 16'hFFFF;
        idle_cycle();
    endtask

    task automatic test_stb();
        logic [15:0] a1, a2, wd; logic [1:0] be; logic rq, wq, ds; int fw, st;
        run_op(MEM_STB, 16'h4003, 16'h12A5, 16'h0, 16'h0, 2, a1, a2, wd, be, rq, wq, fw, st, ds);
        total++; if ({a1, be, wd, rq, wq} !== {16'h4003, 2'b10, 16'hA5A5, 1'b0, 1'b1}) $display("FAIL stb_req: got addr=%h be=%b wdata=%h r=%b w=%b required 4003/10/a5a5/0/1", a1, be, wd, rq, wq); else passed++;
        total++; if (load_data !== model_load) $display("FAIL stb_load_held: got %h required %h", load_data, model_load); else passed++;
        idle_cycle();
    endtask

    task automatic test_indirect();
        logic [15:0] a1, a2, wd; logic [1:0] be; logic rq, wq, ds; int fw, st;
        run_op(MEM_LDI, 16'h5000, 16'h0, 16'h6000, 16'h1234, 2, a1, a2, wd, be, rq, wq, fw, st, ds);
        total++; if ({a1, a2, rq, wq} !== {16'h5000, 16'h6000, 1'b1, 1'b0}) $display("FAIL ldi_addrs: got %h,%h r=%b w=%b required 5000,6000 1/0", a1, a2, rq, wq); else passed++;
        total++; if (load_data !== 16'h1234) $display("FAIL ldi_load: got %h required 1234", load_data); else passed++;
        total++; if (st !== 5) $display("FAIL ldi_stall_cycles: got %0d required 5", st); else passed++;
        model_load = 16'h1234;
        idle_cycle();
        run_op(MEM_STI, 16'h5000, 16'h5A5A, 16'h6000, 16'h0, 1, a1, a2, wd, be, rq, wq, fw, st, ds);
        total++; if ({a1, a2, wd, be, rq, wq} !== {16'h5000, 16'h6000, 16'h5A5A, 2'b11, 1'b0, 1'b1}) $display("FAIL sti_req: got %h,%h wdata=%h be=%b r=%b w=%b required 5000,6000 5a5a 11 0/1", a1, a2, wd, be, rq, wq); else passed++;
        total++; if (load_data !== model_load) $display("FAIL sti_load_held: got %h required %h", load_data, model_load); else passed++;
        idle_cycle();
    endtask

    // Random traffic; back_to_back keeps valid high across DONE so each new op must wait one extra cycle.
    task automatic run_random(input string tag, input int count, input logic back_to_back);
        logic [15:0] a1, a2, wd; logic [1:0] be; logic rq, wq, ds; int fw, st;
        logic [2:0] op; logic [15:0] a, sd, ptr, rd; int lat, fw_exp;
        logic [15:0] ea1, ea2; logic ind;
        for (int i = 0; i < count; i++) begin
            op = 3'($urandom_range(1, 6));
            a = 16'($urandom); sd = 16'($urandom); ptr = 16'($urandom); rd = 16'($urandom);
            lat = $urandom_range(1, 5);
            ind = (op == MEM_LDI || op == MEM_STI);
            fw_exp = (back_to_back && i > 0) ? 2 : 1;
            run_op(op, a, sd, ptr, rd, lat, a1, a2, wd, be, rq, wq, fw, st, ds);
            ea1 = ind ? 16'(a - (a % 2)) : exp_addr(op, a);
            ea2 = ind ? 16'(ptr - (ptr % 2)) : ea1;
            if (!is_st(op)) model_load = ind ? rd : exp_load(op, a, rd);
            total++;
            if ({a1, a2, be, wd, rq, wq} !== {ea1, ea2, exp_be(op, a), exp_wdata(op, sd), !is_st(op), is_st(op)})
                $display("FAIL %s_req[%0d]: op=%0d got %h,%h be=%b wd=%h r=%b w=%b required %h,%h be=%b wd=%h r=%b w=%b",
                         tag, i, op, a1, a2, be, wd, rq, wq, ea1, ea2, exp_be(op, a), exp_wdata(op, sd), !is_st(op), is_st(op));
            else passed++;
            total++; if (load_data !== model_load) $display("FAIL %s_load[%0d]: op=%0d got %h required %h", tag, i, op, load_data, model_load); else passed++;
            total++; if (st !== (ind ? 2 * lat + 1 : lat + 1) || ds !== 1'b0) $display("FAIL %s_stall[%0d]: got %0d cycles done_stall=%b required %0d/0", tag, i, st, ds, ind ? 2 * lat + 1 : lat + 1); else passed++;
            total++; if (fw !== fw_exp) $display("FAIL %s_start_latency[%0d]: got %0d required %0d", tag, i, fw, fw_exp); else passed++;
            if (!back_to_back) idle_cycle();
        end
        if (back_to_back) idle_cycle();
    endtask

    task automatic test_back_to_back();
        run_random("b2b", 8, 1'b1);
    endtask

    task automatic test_random();
        run_random("rand", 25, 1'b0);
        total++; if (unstable !== 0) $display("FAIL request_stability: got %0d changes while waiting required 0", unstable); else passed++;
    endtask

    task automatic test_timeout();
        valid = 1'b1; mem_op = MEM_LDR; addr = 16'h2222; store_data = 16'h0;
        @(negedge clk);
        repeat (MW - 1) @(negedge clk);
        total++; if (mem_err !== 1'b0) $display("FAIL timeout_early: mem_err got %b required 0", mem_err); else passed++;
        @(negedge clk);
        total++; if (mem_err !== 1'b1) $display("FAIL timeout_err: mem_err got %b required 1", mem_err); else passed++;
        total++; if ({mem_stall, dmem_read, dmem_address} !== {1'b1, 1'b1, 16'h2222}) $display("FAIL timeout_waiting: stall=%b read=%b addr=%h required 1/1/2222", mem_stall, dmem_read, dmem_address); else passed++;
        repeat (3) @(negedge clk);
        dmem_rdata = 16'hC0DE; dmem_resp = 1'b1;
        @(negedge clk);
        dmem_resp = 1'b0;
        model_load = 16'hC0DE;
        total++; if ({load_data, mem_stall, mem_err} !== {16'hC0DE, 1'b0, 1'b1}) $display("FAIL timeout_complete: load=%h stall=%b err=%b required c0de/0/1", load_data, mem_stall, mem_err); else passed++;
        idle_cycle();
    endtask

    task automatic test_reset_midaccess();
        int n;
        logic [15:0] a1, a2, wd; logic [1:0] be; logic rq, wq, ds; int fw, st;
        valid = 1'b1; mem_op = MEM_STR; addr = 16'h7001; store_data = 16'h9999;
        n = 0;
        while (!dmem_write && n < 20) begin @(negedge clk); n++; end
        total++; if (dmem_write !== 1'b1) $display("FAIL rst_mid_start: write got %b required 1", dmem_write); else passed++;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if ({dmem_write, dmem_read, dmem_address, dmem_wdata, dmem_byte_enable} !== 36'h0) $display("FAIL rst_mid_req: w=%b r=%b addr=%h wd=%h be=%b required all 0", dmem_write, dmem_read, dmem_address, dmem_wdata, dmem_byte_enable); else passed++;
        total++; if ({load_data, mem_err} !== 17'h0) $display("FAIL rst_mid_state: load=%h err=%b required 0000/0", load_data, mem_err); else passed++;
        model_load = 16'h0;
        idle_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        total++; if ({dmem_write, dmem_read} !== 2'b00) $display("FAIL rst_mid_abandon: got %b required 00", {dmem_write, dmem_read}); else passed++;
        run_op(MEM_LDR, 16'h0102, 16'h0, 16'h0, 16'h4321, 2, a1, a2, wd, be, rq, wq, fw, st, ds);
        total++; if ({a1, load_data, fw} !== {16'h0102, 16'h4321, 32'd1}) $display("FAIL rst_mid_recover: addr=%h load=%h start=%0d required 0102/4321/1", a1, load_data, fw); else passed++;
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_ldr();
        test_ldb();
        test_stb();
        test_indirect();
        test_back_to_back();
        test_random();
        test_timeout();
        test_reset_midaccess();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
